// File: rtl/imem_boot_ctrl_if.sv
// Port bundle for imem_boot_ctrl: byte-stream input, reload/PC from the core,
// instruction-memory write/address port and core status back out.
interface imem_boot_ctrl_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 77
);
  localparam int unsigned INDEX_W = $clog2(DEPTH);

  logic               i_rx_valid;
  logic [7:0]         i_rx_data;
  logic               o_rx_ready;
  logic               i_reload;
  logic [N-1:0]       i_core_addr;
  logic [INDEX_W-1:0] o_mem_addr;
  logic               o_mem_we;
  logic [N-1:0]       o_mem_wdata;
  logic               o_core_hold;
  logic               o_done;
  logic               o_err;
  logic               o_fetch_fault;

  // Controller side
  modport slave (
    input  i_rx_valid, i_rx_data, i_reload, i_core_addr,
    output o_rx_ready, o_mem_addr, o_mem_we, o_mem_wdata,
           o_core_hold, o_done, o_err, o_fetch_fault
  );

  // Stream source / core / memory side
  modport master (
    output i_rx_valid, i_rx_data, i_reload, i_core_addr,
    input  o_rx_ready, o_mem_addr, o_mem_we, o_mem_wdata,
           o_core_hold, o_done, o_err, o_fetch_fault
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot loader for the instruction memory: takes a 16-bit word-count header and
// little-endian words from a byte stream, then hands the address port to the PC.
module imem_boot_ctrl #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 77
) (
  input  logic            i_clk,
  input  logic            i_arst,
  imem_boot_ctrl_if.slave bus
);
  localparam int unsigned INDEX_W = $clog2(DEPTH);
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [1:0] {HDR_LO, HDR_HI, DATA, RUN} state_t;

  typedef struct packed {
    logic [INDEX_W-1:0] idx;
    logic [N-1:0]       data;
  } wr_t;

  state_t      state_q, state_n;
  logic [15:0] count_q, count_n;
  logic [15:0] limit_q, limit_n;
  logic [15:0] word_q, word_n;
  logic [1:0]  pos_q, pos_n;
  logic [23:0] bytes_q, bytes_n;
  wr_t         wr_q, wr_n;
  logic        we_q, we_n;
  logic        err_q, err_n;
  logic        done_q, done_n;

  logic               accept;
  logic               hold_c;
  logic               hold_n;
  logic [15:0]        hdr_count;
  logic [INDEX_W-1:0] fetch_idx;
  logic               unused_addr_bits;

  assign accept    = bus.i_rx_valid && (state_q != RUN);
  assign hdr_count = {bus.i_rx_data, count_q[7:0]};
  assign hold_c    = (state_q != RUN) || we_q;
  assign fetch_idx = bus.i_core_addr[2 +: INDEX_W];
  assign unused_addr_bits = ^{bus.i_core_addr[N-1:2+INDEX_W], bus.i_core_addr[1:0]};

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= HDR_LO;
      count_q <= '0;
      limit_q <= '0;
      word_q  <= '0;
      pos_q   <= '0;
      bytes_q <= '0;
      wr_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      limit_q <= limit_n;
      word_q  <= word_n;
      pos_q   <= pos_n;
      bytes_q <= bytes_n;
      wr_q    <= wr_n;
      we_q    <= we_n;
      err_q   <= err_n;
      done_q  <= done_n;
    end
  end

  // Next-state: reload wins over any byte presented on the same edge
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    limit_n = limit_q;
    word_n  = word_q;
    pos_n   = pos_q;
    bytes_n = bytes_q;
    wr_n    = wr_q;
    we_n    = 1'b0;
    err_n   = err_q;

    if (bus.i_reload) begin
      state_n = HDR_LO;
      count_n = '0;
      limit_n = '0;
      word_n  = '0;
      pos_n   = '0;
      bytes_n = '0;
      err_n   = 1'b0;
    end else if (accept) begin
      case (state_q)
        HDR_LO: begin
          count_n = {8'h00, bus.i_rx_data};
          state_n = HDR_HI;
        end
        HDR_HI: begin
          count_n = hdr_count;
          if (hdr_count == 16'd0) begin
            state_n = RUN;
          end else begin
            if (hdr_count > DEPTH_W) begin
              err_n   = 1'b1;
              limit_n = DEPTH_W;
            end else begin
              limit_n = hdr_count;
            end
            pos_n   = '0;
            word_n  = '0;
            state_n = DATA;
          end
        end
        DATA: begin
          pos_n = pos_q + 2'd1;
          if (pos_q == 2'd3) begin
            // Words beyond the memory are counted but dropped
            if (word_q < limit_q) begin
              we_n      = 1'b1;
              wr_n.idx  = INDEX_W'(word_q);
              wr_n.data = {bus.i_rx_data, bytes_q};
            end
            word_n = word_q + 16'd1;
            if ((word_q + 16'd1) == count_q) begin
              state_n = RUN;
            end
          end else begin
            case (pos_q)
              2'd0:    bytes_n[7:0]   = bus.i_rx_data;
              2'd1:    bytes_n[15:8]  = bus.i_rx_data;
              default: bytes_n[23:16] = bus.i_rx_data;
            endcase
          end
        end
        default: begin
        end
      endcase
    end

    hold_n = (state_n != RUN) || we_n;
    done_n = hold_c && !hold_n;
  end

  // A pending write owns the address port ahead of the PC
  assign bus.o_mem_addr    = we_q ? wr_q.idx
                                  : ((state_q == RUN) ? fetch_idx : INDEX_W'(word_q));
  assign bus.o_mem_we      = we_q;
  assign bus.o_mem_wdata   = wr_q.data;
  assign bus.o_core_hold   = hold_c;
  assign bus.o_rx_ready    = (state_q != RUN);
  assign bus.o_done        = done_q;
  assign bus.o_err         = err_q;
  assign bus.o_fetch_fault = !hold_c && (32'(fetch_idx) >= DEPTH);
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized bench for imem_boot_ctrl against a byte-count reference model.
`timescale 1ns/1ps
module tb_imem_boot_ctrl;
  localparam int unsigned N       = 32;
  localparam int unsigned DEPTH   = 77;
  localparam int unsigned INDEX_W = $clog2(DEPTH);

  logic clk = 1'b0;
  logic arst;

  imem_boot_ctrl_if #(.N(N), .DEPTH(DEPTH)) bus ();
  imem_boot_ctrl #(.N(N), .DEPTH(DEPTH)) dut (.i_clk(clk), .i_arst(arst), .bus(bus));

  always #10 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  // Reference model: everything follows from bytes accepted since the load began
  int          m_n;
  int          m_cnt;
  bit          m_run, m_err, m_we, m_done, m_prev_hold, m_acc;
  int          m_idx;
  logic [31:0] m_wdata;
  logic [7:0]  m_buf [4];

  logic [31:0] words [$];
  int          wq_idx [$];
  logic [31:0] wq_data [$];
  int          done_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_cnt = 0; m_run = 0; m_err = 0; m_we = 0; m_done = 0;
    m_prev_hold = 1; m_acc = 0; m_idx = 0; m_wdata = '0;
  endtask

  task automatic model_step();
    bit hold;
    int w, p;
    m_we  = 0;
    m_acc = 0;
    if (bus.i_reload) begin
      m_n = 0; m_cnt = 0; m_err = 0; m_run = 0;
    end else if (bus.i_rx_valid && !m_run) begin
      m_acc = 1;
      if (m_n == 0) begin
        m_cnt = int'(bus.i_rx_data);
      end else if (m_n == 1) begin
        m_cnt = m_cnt + 256 * int'(bus.i_rx_data);
        m_err = (m_cnt > int'(DEPTH));
        m_run = (m_cnt == 0);
      end else begin
        w = (m_n - 2) / 4;
        p = (m_n - 2) % 4;
        m_buf[p] = bus.i_rx_data;
        if (p == 3) begin
          if (w < int'(DEPTH)) begin
            m_we = 1; m_idx = w;
            m_wdata = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
          end
          if (w + 1 == m_cnt) m_run = 1;
        end
      end
      m_n = m_n + 1;
    end
    hold = !m_run || m_we;
    m_done = m_prev_hold && !hold;
    m_prev_hold = hold;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!arst) model_step();
    #1;
  endtask

  task automatic idle(input int n);
    bus.i_rx_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic reload_pulse();
    bus.i_rx_valid = 1'b0;
    bus.i_reload = 1'b1;
    tick();
    bus.i_reload = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    tries = 0;
    do begin
      bus.i_rx_valid = (int'($urandom_range(99)) >= gap);
      bus.i_rx_data  = bus.i_rx_valid ? b : 8'($urandom);
      tick();
      tries++;
    end while (!m_acc && tries < 400);
    if (!m_acc) chk("send_accept", 32'(m_acc), 32'd1);
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic fill_words(input int n);
    words.delete();
    repeat (n) words.push_back($urandom);
  endtask

  task automatic load(input int cnt, input int gap, input int max_bytes);
    logic [7:0] b;
    for (int i = 0; i < 2 + 4 * cnt && i < max_bytes; i++) begin
      if (i == 0)      b = 8'(cnt);
      else if (i == 1) b = 8'(cnt >> 8);
      else             b = 8'(words[(i - 2) / 4] >> (8 * ((i - 2) % 4)));
      send_byte(b, gap);
    end
  endtask

  task automatic clear_capture();
    wq_idx.delete();
    wq_data.delete();
    done_cnt = 0;
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge
  initial begin
    logic [INDEX_W-1:0] ea;
    int fi;
    forever begin
      @(negedge clk);
      if (chk_en && !arst) begin
        fi = int'((bus.i_core_addr >> 2) % (32'd1 << INDEX_W));
        if (m_we)       ea = INDEX_W'(m_idx);
        else if (m_run) ea = INDEX_W'(fi);
        else            ea = INDEX_W'((m_n >= 2) ? (m_n - 2) / 4 : 0);
        chk("we",    32'(bus.o_mem_we),    32'(m_we));
        chk("hold",  32'(bus.o_core_hold), 32'(!m_run || m_we));
        chk("ready", 32'(bus.o_rx_ready),  32'(!m_run));
        chk("done",  32'(bus.o_done),      32'(m_done));
        chk("err",   32'(bus.o_err),       32'(m_err));
        chk("addr",  32'(bus.o_mem_addr),  32'(ea));
        chk("fault", 32'(bus.o_fetch_fault), 32'(m_run && !m_we && fi >= int'(DEPTH)));
        if (m_we) chk("wdata", bus.o_mem_wdata, m_wdata);
        if (bus.o_mem_we) begin
          wq_idx.push_back(int'(bus.o_mem_addr));
          wq_data.push_back(bus.o_mem_wdata);
        end
        if (bus.o_done) done_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, gap, maxb;
    arst = 1'b1;
    bus.i_rx_valid = 1'b0; bus.i_rx_data = '0; bus.i_reload = 1'b0; bus.i_core_addr = '0;
    model_reset();
    clear_capture();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold",  32'(bus.o_core_hold), 32'd1);
    chk("rst_ready", 32'(bus.o_rx_ready),  32'd1);
    chk("rst_we",    32'(bus.o_mem_we),    32'd0);
    chk("rst_wdata", bus.o_mem_wdata,      32'd0);
    chk("rst_done",  32'(bus.o_done),      32'd0);
    chk("rst_err",   32'(bus.o_err),       32'd0);
    arst = 1'b0;
    chk_en = 1'b1;

    // Basic two-word load at full rate
    words.delete();
    words.push_back(32'h0000_0013);
    words.push_back(32'h0020_81b3);
    load(2, 0, 1000);
    idle(3);
    chk("basic_nwr",   32'(wq_idx.size()), 32'd2);
    chk("basic_idx0",  32'(wq_idx[0]), 32'd0);
    chk("basic_dat0",  wq_data[0], 32'h0000_0013);
    chk("basic_idx1",  32'(wq_idx[1]), 32'd1);
    chk("basic_dat1",  wq_data[1], 32'h0020_81b3);
    chk("basic_done",  32'(done_cnt), 32'd1);
    bus.i_core_addr = 32'h4;
    #1 chk("fetch_addr", 32'(bus.o_mem_addr), 32'd1);
    bus.i_core_addr = 32'h134;
    #1 chk("fault_hi", 32'(bus.o_fetch_fault), 32'd1);
    bus.i_core_addr = 32'h133;
    #1 chk("fault_lo", 32'(bus.o_fetch_fault), 32'd0);
    idle(1);

    // Overflow: 80 words into a 77-word memory
    reload_pulse();
    fill_words(80);
    clear_capture();
    load(80, 0, 2);
    chk("ovf_err", 32'(bus.o_err), 32'd1);
    for (int i = 0; i < 80; i++) load(80, 0, 0);
    begin
      for (int i = 2; i < 2 + 4 * 80; i++)
        send_byte(8'(words[(i - 2) / 4] >> (8 * ((i - 2) % 4))), 0);
    end
    chk("ovf_bytes",  32'(m_n), 32'd322);
    chk("ovf_hold",   32'(bus.o_core_hold), 32'd0);
    chk("ovf_ready",  32'(bus.o_rx_ready), 32'd0);
    idle(2);
    chk("ovf_nwr",    32'(wq_idx.size()), 32'd77);
    chk("ovf_lastix", 32'(wq_idx[76]), 32'd76);
    chk("ovf_lastd",  wq_data[76], words[76]);

    // Reload from RUN clears the error and holds the core again
    reload_pulse();
    chk("rl_hold",  32'(bus.o_core_hold), 32'd1);
    chk("rl_err",   32'(bus.o_err), 32'd0);
    chk("rl_ready", 32'(bus.o_rx_ready), 32'd1);

    // Zero-count header
    clear_capture();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("zero_hold",  32'(bus.o_core_hold), 32'd0);
    chk("zero_done",  32'(bus.o_done), 32'd1);
    chk("zero_ready", 32'(bus.o_rx_ready), 32'd0);
    idle(2);
    chk("zero_nwr",   32'(wq_idx.size()), 32'd0);

    // Reload after two bytes of a word, with a byte on the reload edge
    reload_pulse();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'haa, 0); send_byte(8'hbb, 0);
    bus.i_reload = 1'b1; bus.i_rx_valid = 1'b1; bus.i_rx_data = 8'hcc;
    tick();
    bus.i_reload = 1'b0; bus.i_rx_valid = 1'b0;
    words.delete();
    words.push_back(32'h1122_3344);
    clear_capture();
    load(1, 0, 1000);
    idle(2);
    chk("rlmid_nwr", 32'(wq_idx.size()), 32'd1);
    chk("rlmid_idx", 32'(wq_idx[0]), 32'd0);
    chk("rlmid_dat", wq_data[0], 32'h1122_3344);

    // Stream gaps over a four-word load
    reload_pulse();
    fill_words(4);
    clear_capture();
    load(4, 50, 1000);
    idle(2);
    chk("gap_nwr", 32'(wq_idx.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("gap_idx", 32'(wq_idx[i]), 32'(i));
      chk("gap_dat", wq_data[i], words[i]);
    end

    // Async reset between edges while a write is in flight
    reload_pulse();
    fill_words(2);
    load(2, 0, 6);
    bus.i_rx_valid = 1'b1; bus.i_rx_data = 8'h77;
    #2 arst = 1'b1;
    #1;
    chk("arst_we",    32'(bus.o_mem_we), 32'd0);
    chk("arst_hold",  32'(bus.o_core_hold), 32'd1);
    chk("arst_ready", 32'(bus.o_rx_ready), 32'd1);
    model_reset();
    #2 arst = 1'b0;
    clear_capture();
    tick();
    bus.i_rx_valid = 1'b0;
    chk("arst_nowr", 32'(bus.o_mem_we), 32'd0);
    reload_pulse();
    fill_words(3);
    clear_capture();
    load(3, 20, 1000);
    idle(2);
    chk("arst_nwr",  32'(wq_idx.size()), 32'd3);
    chk("arst_idx0", 32'(wq_idx[0]), 32'd0);

    // Randomized loads, some aborted by reload, with random fetch addresses
    for (int it = 0; it < 10; it++) begin
      reload_pulse();
      cnt  = ($urandom_range(9) < 7) ? int'($urandom_range(8)) : int'($urandom_range(82, 74));
      gap  = int'($urandom_range(40));
      maxb = ($urandom_range(3) == 0) ? int'($urandom_range(2 + 4 * cnt)) : 100000;
      fill_words(cnt);
      load(cnt, gap, maxb);
      for (int k = 0; k < 5; k++) begin
        bus.i_core_addr = $urandom;
        tick();
      end
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot-load and port-sharing controller for the core's instruction memory. After reset it holds the core and fills the instruction memory from an external byte stream, such as a UART receiver. The stream is a 16-bit word-count header followed by little-endian 32-bit instruction words. Once the load finishes it releases the core, hands the memory address port to the fetch PC, and can restart a load on request.

## Interface
- N, 32, instruction/data word width (fixed 32 for RV32I).
- DEPTH, 77, instruction memory depth in words.
- INDEX_W, $clog2(DEPTH), word-index width (derived, not overridden).

Ports:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_arst  in  1  asynchronous reset, active-high.
- i_rx_valid  in  1  byte-stream valid.
- i_rx_data  in  8  byte-stream data.
- o_rx_ready  out  1  byte accepted on any edge where i_rx_valid && o_rx_ready.
- i_reload  in  1  restart load sequence (level, sampled each edge).
- i_core_addr  in  N  core fetch byte address (PC).
- o_mem_addr  out  INDEX_W  instruction memory word index.
- o_mem_we  out  1  instruction memory write enable.
- o_mem_wdata  out  N  instruction memory write data.
- o_core_hold  out  1  core stall/hold while memory is not valid.
- o_done  out  1  one-cycle pulse: load complete, core released.
- o_err  out  1  sticky: header count exceeded DEPTH.
- o_fetch_fault  out  1  combinational, in run with hold low: fetch index >= DEPTH.

## Operation
- States:
  - HDR_LO: accept byte into count[7:0].
  - HDR_HI: accept byte into count[15:8].
  - DATA: receive instruction words.
  - RUN: core owns the address port.
- HDR_HI on accept:
  - count==0 -> RUN.
  - count>DEPTH -> set o_err; write limit = DEPTH.
  - Otherwise write limit = count.
  - In both nonzero cases -> DATA, with byte counter and word counter cleared.
- DATA, per accepted byte:
  - Byte position 0..3 places the byte in wdata[8p+7:8p] (little-endian).
  - Byte 3 completes a word. If word counter < limit, register a write (we_q, idx_q = word counter, wdata_q = assembled word). Otherwise discard it (drain).
  - The word counter (16-bit) increments on every completed word.
  - When completed words == count -> RUN.
- RUN: o_rx_ready=0; fetch index = i_core_addr[2 +: INDEX_W]; i_core_addr[1:0] ignored.
- Address mux priority: we_q ? idx_q : (state==RUN ? fetch index : word counter).
- o_core_hold = (state != RUN) || we_q.
- o_rx_ready = 1 in HDR_LO, HDR_HI and DATA.
- i_reload high in any state -> HDR_LO next edge; clears counters and o_err. A byte presented that same edge is discarded. A pending we_q still completes.
- Reset values, applied immediately on i_arst:
  - state HDR_LO; counters 0; o_err 0.
  - o_mem_we 0, o_mem_wdata 0, o_done 0.
  - o_core_hold 1, o_rx_ready 1.

## Timing
- Byte accepted at edge k. If it completes a writable word, o_mem_we=1 for exactly cycle k..k+1, with o_mem_addr/o_mem_wdata stable that cycle.
- Last word accepted at edge k: state=RUN from k. o_core_hold stays 1 through cycle k..k+1 (pending write), then drops at edge k+1.
- o_done is 1 for the single cycle in which o_core_hold first goes low after a load.
- count==0: RUN and o_done at the edge after HDR_HI accept. No write occurs.
- Minimum load time is 2 + 4·count accepted bytes. Gaps in i_rx_valid stall the counters without loss.
- Back-to-back words at full rate produce one write per 4 cycles. A write never collides with the next word.
- Reset mid-load: memory contents written so far are left untouched. The next header starts a fresh load from index 0.

## Test plan
- Basic load:
  - Stimulus: reset; bytes 02 00 13 00 00 00 b3 81 20 00 at full rate.
  - Required: idx0=0x00000013, then idx1=0x002081b3, one o_mem_we cycle each. o_done is a single pulse and o_core_hold falls the same cycle. In RUN with i_core_addr=0x4, o_mem_addr=1.
- Zero count:
  - Stimulus: header 00 00.
  - Required: no o_mem_we; RUN, o_done and o_core_hold=0 one edge after the second byte; o_rx_ready=0.
- Overflow:
  - Stimulus: header 50 00 (80 words) with DEPTH=77.
  - Required: o_err=1 after header; exactly 77 writes, idx 0..76; 3 words drained with no writes; RUN after byte 322.
- Stream gaps:
  - Stimulus: i_rx_valid toggled 1-0-0-1 pseudo-randomly over a 4-word load.
  - Required: data identical to the full-rate case; no extra or missing writes.
- Reload:
  - Stimulus 1: i_reload pulse in RUN. Required: HDR_LO next edge, o_core_hold=1, o_err=0.
  - Stimulus 2: i_reload during DATA after 2 bytes of a word. Required: partial word discarded; the subsequent load writes from idx0.
- Async reset:
  - Stimulus: assert i_arst mid-DATA, between edges.
  - Required: o_mem_we=0, o_core_hold=1, o_rx_ready=1 immediately; no write on the following edge.
